ldpc_3gpp_enc_hb_seq: RTL

//  Row/word sequencer for the fixed-mode 3GPP LDPC encoder Hb table reader.

---
 rtl/ldpc_3gpp_enc_hb_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ldpc_3gpp_enc_hb_seq.sv
// ldpc_3gpp_enc_hb_seq: row/word sequencer for the fixed-mode 3GPP LDPC Hb table reader.
// Walks core (phase 0), psi solve (phase 1) and extension rows 4..lr (phase 2),
// one zc-word segment per row, with a one-cycle LOAD bubble before each segment.
// Ports:
//   iclk, ireset (async, active-high), iclkena (low freezes everything)
//   istart, iused_zc, iused_row : encode request and geometry, latched in IDLE
//   irdy                        : engine accepts the current step
//   orow, oval, ophase, oword   : table row select and current step
//   osop, oeop, olast           : registered segment/encode position tags
//   obusy, odone                : encode in flight / one-cycle completion pulse
module ldpc_3gpp_enc_hb_seq #(
    parameter int pROW_W = 6,
    parameter int pZC_W  = 9
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              istart,
    input  logic [pZC_W-1:0]  iused_zc,
    input  logic [pROW_W-1:0] iused_row,
    input  logic              irdy,
    output logic [pROW_W-1:0] orow,
    output logic              oval,
    output logic [1:0]        ophase,
    output logic [pZC_W-1:0]  oword,
    output logic              osop,
    output logic              oeop,
    output logic              olast,
    output logic              obusy,
    output logic              odone
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
    state_t            state_q, state_d;
    logic [pZC_W-1:0]  zc_q, zc_d, word_q, word_d;
    logic [pROW_W-1:0] lr_q, lr_d, row_q, row_d;
    logic [1:0]        phase_q, phase_d;
    logic              val_q, val_d, sop_q, sop_d, eop_q, eop_d;
    logic              last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic              consume, seg_end;
    assign consume = val_q & irdy;
    assign seg_end = word_q == zc_q - 1'b1;
    always_comb begin
        state_d = state_q;
        zc_d    = zc_q;
        lr_d    = lr_q;
        word_d  = word_q;
        row_d   = row_q;
        phase_d = phase_q;
        val_d   = val_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (istart) begin
                zc_d    = (iused_zc == '0) ? pZC_W'(1) : iused_zc;
                lr_d    = (iused_row < pROW_W'(4)) ? pROW_W'(4) : iused_row;
                phase_d = 2'd0;
                row_d   = '0;
                word_d  = '0;
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            // bubble: the Hb table needs one cycle to present the row just selected
            LOAD: begin
                state_d = RUN;
                word_d  = '0;
                val_d   = 1'b1;
            end
            RUN: if (consume) begin
                if (!seg_end) begin
                    word_d = word_q + 1'b1;
                end else begin
                    // row only moves here, so the table output stays put across stalls
                    word_d  = '0;
                    val_d   = 1'b0;
                    state_d = LOAD;
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                        row_d   = '0;
                    end else if (phase_q == 2'd1) begin
                        phase_d = 2'd2;
                        row_d   = pROW_W'(4);
                    end else if (row_q < lr_q) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                phase_d = 2'd0;
                row_d   = '0;
                word_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        sop_d  = val_d & (word_d == '0);
        eop_d  = val_d & (word_d == zc_d - 1'b1);
        last_d = eop_d & (phase_d == 2'd2) & (row_d == lr_d);
    end
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q <= IDLE;
            zc_q    <= '0;
            lr_q    <= '0;
            word_q  <= '0;
            row_q   <= '0;
            phase_q <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (iclkena) begin
            state_q <= state_d;
            zc_q    <= zc_d;
            lr_q    <= lr_d;
            word_q  <= word_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign orow   = row_q;
    assign oval   = val_q;
    assign ophase = phase_q;
    assign oword  = word_q;
    assign osop   = sop_q;
    assign oeop   = eop_q;
    assign olast  = last_q;
    assign obusy  = busy_q;
    assign odone  = done_q;
endmodule
